fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the pipeline: owns the PC, issues requests to instruction memory, buffers returned words in a small prefetch FIFO, and presents one instruction per cycle to decode.
- Sits directly upstream of decode. Consumes the hazard unit's stall_fetch and stall_pc controls and the execute-stage branch redirect.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- INSTR_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 4, PC increment per sequential fetch.
- DEPTH, 2, prefetch FIFO entries; also the maximum in-flight plus buffered instructions.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_fetch_i  in  1  decode must not consume; hold the current head instruction.
- stall_pc_i  in  1  freeze the PC; issue no new request.
- branch_i  in  1  redirect pulse from execute.
- branch_target_i  in  ADDR_W  new PC, valid with branch_i.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  ADDR_W  request address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid. Responses return in order, at least one cycle after gnt.
- imem_rdata_i  in  INSTR_W  response data.
- instr_valid_o  out  1  instr_o and instr_pc_o are valid.
- instr_o  out  INSTR_W  instruction at the FIFO head.
- instr_pc_o  out  ADDR_W  PC of instr_o.

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - FIFO empty, outstanding = 0, discard = 0.
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
- Credit rule: a request may be raised only when occupancy + outstanding < DEPTH.
  - The credit check counts a pop in the same cycle.
  - It does not count a push in the same cycle.
- Request issue:
  - imem_req_o = credit && !stall_pc_i && !branch_i, or a request is already pending without gnt.
  - imem_addr_o = PC.
  - While req=1 and gnt=0, req and addr hold stable regardless of stall_pc_i or branch_i.
- On req && gnt: outstanding += 1, and PC += PC_INC (wraps modulo 2^ADDR_W).
  - The PC tag of each issued request travels with it in a DEPTH-entry in-order tag queue.
- On rvalid:
  - If discard > 0: drop the word and decrement discard.
  - Otherwise push {rdata, tag} into the FIFO.
  - In both cases outstanding -= 1.
- Output:
  - instr_valid_o = FIFO non-empty; instr_o and instr_pc_o come from the head entry.
  - There is no bypass: a response becomes visible the cycle after its rvalid.
- Pop: instr_valid_o && !stall_fetch_i && !branch_i.
  - Simultaneous push and pop is legal, including when the FIFO is full.
- stall_fetch_i: head entry and outputs are held unchanged; prefetch continues up to the credit limit.
- stall_pc_i: PC is held and no new request is raised. An already pending request still completes.
- Redirect (branch_i=1), which has priority over both stalls:
  - FIFO is flushed, so instr_valid_o = 0 next cycle.
  - PC <= branch_target_i. If a pending request is granted in the same cycle, branch_target_i still wins; the granted request is counted for discard.
  - discard <= outstanding after this cycle's gnt/rvalid updates.
  - A pending un-granted request completes at its old address and its response is discarded.
- Latency: request granted in cycle N, rvalid in cycle N+1, instr_valid_o in cycle N+2.
  - Back-to-back zero-wait memory sustains 1 instruction per cycle once the FIFO is primed.
- Invariant: occupancy + outstanding <= DEPTH at all times.
- An rvalid arriving with outstanding = 0 is a protocol error: flag it with an assertion and ignore it.
- Reset mid-operation: all state returns to reset values the next cycle. Instruction memory is reset by the same rst_i, so no stale responses arrive afterwards.

Test Plan:
- Reset release with a zero-wait memory returning word = address -> req in cycle 0 at addr 0. instr_valid_o rises in cycle 2 with instr_o = 0x0, then 0x4, 0x8 on consecutive cycles.
- stall_fetch_i held high for 5 cycles with DEPTH=2 -> instr_o stays at 0x0; at most 2 requests granted; req drops to 0. Release -> 0x4, 0x8 follow without bubble.
- stall_pc_i high for 3 cycles while gnt=0 on a pending request to 0x8 -> addr stays 0x8 until gnt; no further request until stall_pc_i drops.
- branch_i with target 0x100 while 2 requests are outstanding -> both responses dropped. First valid output is instr_pc_o = 0x100 with instr_o = 0x100.
- Response delay of 3 cycles with DEPTH=2 -> never more than 2 outstanding; instructions arrive in order 0x0, 0x4, 0x8 with correct PC tags.
- PC near 2^ADDR_W-4 and rst_i asserted mid-burst -> PC wraps to 0. After reset, PC = RESET_PC and the FIFO is empty the next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited requests to instruction
// memory and buffers in-order responses in a small prefetch FIFO feeding decode.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4,
    parameter int                DEPTH    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_fetch_i,
    input  logic               stall_pc_i,
    input  logic               branch_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pending_q, pending_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic               stale_q, stale_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   disc_cnt_q, disc_cnt_d;
    logic [CNT_W-1:0]   f_cnt_q, f_cnt_d;
    logic [PTR_W-1:0]   f_rd_q, f_wr_q;
    logic [PTR_W-1:0]   t_rd_q, t_wr_q;
    logic [INSTR_W-1:0] fifo_data_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q   [DEPTH];
    logic [ADDR_W-1:0]  tag_q       [DEPTH];

    logic              fifo_valid;
    logic              pop;
    logic              push;
    logic              resp_ok;
    logic              drop;
    logic              credit;
    logic              req;
    logic              fire;
    logic [CNT_W:0]    used_cnt;
    logic [ADDR_W-1:0] req_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: a request transfers on a cycle where imem_req_o && imem_gnt_i; once raised,
    // req/addr stay fixed until granted. Each transfer returns exactly one imem_rvalid_i
    // beat, in order, at least one cycle later. Decode consumes when instr_valid_o && !stall.
    always_comb begin
        fifo_valid = (f_cnt_q != '0);
        pop        = fifo_valid && !stall_fetch_i && !branch_i;
        resp_ok    = imem_rvalid_i && (out_cnt_q != '0);
        push       = resp_ok && (disc_cnt_q == '0) && !branch_i;
        drop       = resp_ok && (disc_cnt_q != '0);
        used_cnt   = {1'b0, f_cnt_q} + {1'b0, out_cnt_q} - (CNT_W + 1)'(pop);
        credit     = used_cnt < (CNT_W + 1)'(DEPTH);
        req        = !rst_i && (pending_q || (credit && !stall_pc_i && !branch_i));
        req_addr   = pending_q ? pend_addr_q : pc_q;
        fire       = req && imem_gnt_i;
    end

    always_comb begin
        pc_d        = pc_q;
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        stale_d     = stale_q;
        out_cnt_d   = out_cnt_q + CNT_W'(fire) - CNT_W'(resp_ok);
        disc_cnt_d  = disc_cnt_q - CNT_W'(drop);
        f_cnt_d     = f_cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (fire) begin
            pending_d = 1'b0;
            stale_d   = 1'b0;
            // A request raised before a redirect still completes, but its word is wrong-path.
            if (stale_q) begin
                disc_cnt_d = disc_cnt_q + CNT_W'(1) - CNT_W'(drop);
            end else begin
                pc_d = pc_q + ADDR_W'(PC_INC);
            end
        end else if (req) begin
            pending_d   = 1'b1;
            pend_addr_d = req_addr;
            if (branch_i) begin
                stale_d = 1'b1;
            end
        end

        if (branch_i) begin
            pc_d       = branch_target_i;
            disc_cnt_d = out_cnt_d;
            f_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            stale_q     <= 1'b0;
            out_cnt_q   <= '0;
            disc_cnt_q  <= '0;
            f_cnt_q     <= '0;
            f_rd_q      <= '0;
            f_wr_q      <= '0;
            t_rd_q      <= '0;
            t_wr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                tag_q[i]       <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            stale_q     <= stale_d;
            out_cnt_q   <= out_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            f_cnt_q     <= f_cnt_d;

            // Tag queue mirrors the outstanding requests and is never flushed.
            if (fire) begin
                tag_q[t_wr_q] <= req_addr;
                t_wr_q        <= ptr_inc(t_wr_q);
            end
            if (resp_ok) begin
                t_rd_q <= ptr_inc(t_rd_q);
            end

            if (push) begin
                fifo_data_q[f_wr_q] <= imem_rdata_i;
                fifo_pc_q[f_wr_q]   <= tag_q[t_rd_q];
            end
            if (branch_i) begin
                f_rd_q <= '0;
                f_wr_q <= '0;
            end else begin
                if (push) begin
                    f_wr_q <= ptr_inc(f_wr_q);
                end
                if (pop) begin
                    f_rd_q <= ptr_inc(f_rd_q);
                end
            end

            a_no_spurious_rvalid: assert (!imem_rvalid_i || (out_cnt_q != '0));
            a_credit_bound: assert (({1'b0, f_cnt_q} + {1'b0, out_cnt_q}) <= (CNT_W + 1)'(DEPTH));
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = req_addr;
    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_valid ? fifo_data_q[f_rd_q] : '0;
    assign instr_pc_o    = fifo_valid ? fifo_pc_q[f_rd_q] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a responder memory returns word = address with a
// selectable fixed latency; each step checks outputs at the falling edge.
module tb_fetch_unit;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               stall_fetch = 1'b0;
    logic               stall_pc    = 1'b0;
    logic               branch      = 1'b0;
    logic [ADDR_W-1:0]  target      = '0;
    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i = 1'b0;
    logic [INSTR_W-1:0] imem_rdata_i  = '0;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc_o;

    fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0), .PC_INC(4), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .stall_fetch_i(stall_fetch), .stall_pc_i(stall_pc),
        .branch_i(branch), .branch_target_i(target),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o)
    );

    // memory responder
    logic        gnt_en    = 1'b1;
    int          mem_delay = 1;
    logic        fire_s    = 1'b0;
    logic [31:0] addr_s    = '0;
    logic [31:0] resp_addr_q[$];
    int          resp_due_q[$];
    int          cyc       = 0;
    int          gnt_count = 0;
    int          max_out   = 0;

    assign imem_gnt_i = gnt_en;

    always @(negedge clk) begin
        fire_s = imem_req_o && imem_gnt_i;
        addr_s = imem_addr_o;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            resp_addr_q.delete();
            resp_due_q.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end else begin
            if (fire_s) begin
                resp_addr_q.push_back(addr_s);
                resp_due_q.push_back(cyc + mem_delay - 1);
                gnt_count++;
            end
            if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = resp_addr_q.pop_front();
                void'(resp_due_q.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
            end
            if (resp_addr_q.size() + int'(imem_rvalid_i) > max_out) begin
                max_out = resp_addr_q.size() + int'(imem_rvalid_i);
            end
        end
    end

    // scoreboard
    logic [INSTR_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int g0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        logic [INSTR_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(instr_valid_o), 64'd1);
            check({tag, "_instr"}, 64'(instr_o), 64'(e));
            check({tag, "_pc"}, 64'(instr_pc_o), 64'(e));
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int delay);
        rst         = 1'b1;
        stall_fetch = 1'b0;
        stall_pc    = 1'b0;
        branch      = 1'b0;
        target      = '0;
        gnt_en      = 1'b1;
        mem_delay   = delay;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // reset values, then zero-wait streaming
        next_cycle();
        @(negedge clk);
        check("rst_req", 64'(imem_req_o), 64'd0);
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_instr", 64'(instr_o), 64'd0);
        check("rst_pc", 64'(instr_pc_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("a0_req", 64'(imem_req_o), 64'd1);
        check("a0_addr", 64'(imem_addr_o), 64'h0);
        check("a0_valid", 64'(instr_valid_o), 64'd0);
        next_cycle(); @(negedge clk);
        check("a1_valid", 64'(instr_valid_o), 64'd0);
        check("a1_addr", 64'(imem_addr_o), 64'h4);
        next_cycle(); @(negedge clk);
        check("a2_valid", 64'(instr_valid_o), 64'd1);
        check("a2_instr", 64'(instr_o), 64'h0);
        check("a2_pc", 64'(instr_pc_o), 64'h0);
        next_cycle(); @(negedge clk);
        check("a3_instr", 64'(instr_o), 64'h4);
        check("a3_pc", 64'(instr_pc_o), 64'h4);
        next_cycle(); @(negedge clk);
        check("a4_instr", 64'(instr_o), 64'h8);
        check("a4_pc", 64'(instr_pc_o), 64'h8);

        // decode stall: prefetch fills to the credit limit then stops
        do_reset(1);
        stall_fetch = 1'b1;
        g0 = gnt_count;
        @(negedge clk);
        next_cycle(); @(negedge clk);
        next_cycle(); @(negedge clk);
        check("b2_valid", 64'(instr_valid_o), 64'd1);
        check("b2_instr", 64'(instr_o), 64'h0);
        next_cycle(); @(negedge clk);
        check("b3_req", 64'(imem_req_o), 64'd0);
        next_cycle();
        next_cycle();
        next_cycle(); @(negedge clk);
        check("b6_instr", 64'(instr_o), 64'h0);
        check("b6_req", 64'(imem_req_o), 64'd0);
        check("b6_grants", 64'(gnt_count - g0), 64'd2);
        next_cycle();
        stall_fetch = 1'b0;
        @(negedge clk);
        check("b7_instr", 64'(instr_o), 64'h0);
        check("b7_req", 64'(imem_req_o), 64'd1);
        check("b7_addr", 64'(imem_addr_o), 64'h8);
        next_cycle(); @(negedge clk);
        check("b8_valid", 64'(instr_valid_o), 64'd1);
        check("b8_instr", 64'(instr_o), 64'h4);
        next_cycle(); @(negedge clk);
        check("b9_instr", 64'(instr_o), 64'h8);
        check("b9_pc", 64'(instr_pc_o), 64'h8);

        // PC stall while a request to 0x8 waits for grant
        do_reset(1);
        @(negedge clk);
        next_cycle(); @(negedge clk);
        next_cycle();
        gnt_en = 1'b0;
        @(negedge clk);
        check("c2_req", 64'(imem_req_o), 64'd1);
        check("c2_addr", 64'(imem_addr_o), 64'h8);
        next_cycle();
        stall_pc = 1'b1;
        @(negedge clk);
        check("c3_req", 64'(imem_req_o), 64'd1);
        check("c3_addr", 64'(imem_addr_o), 64'h8);
        check("c3_instr", 64'(instr_o), 64'h4);
        next_cycle(); @(negedge clk);
        check("c4_addr", 64'(imem_addr_o), 64'h8);
        check("c4_valid", 64'(instr_valid_o), 64'd0);
        next_cycle();
        gnt_en = 1'b1;
        @(negedge clk);
        check("c5_req", 64'(imem_req_o), 64'd1);
        check("c5_addr", 64'(imem_addr_o), 64'h8);
        next_cycle(); @(negedge clk);
        check("c6_req", 64'(imem_req_o), 64'd0);
        next_cycle();
        stall_pc = 1'b0;
        @(negedge clk);
        check("c7_req", 64'(imem_req_o), 64'd1);
        check("c7_addr", 64'(imem_addr_o), 64'hC);
        check("c7_instr", 64'(instr_o), 64'h8);
        check("c7_pc", 64'(instr_pc_o), 64'h8);

        // redirect with two requests outstanding (3-cycle memory)
        do_reset(3);
        @(negedge clk);
        next_cycle(); @(negedge clk);
        next_cycle();
        branch = 1'b1;
        target = 32'h100;
        @(negedge clk);
        check("d2_req", 64'(imem_req_o), 64'd0);
        next_cycle();
        branch = 1'b0;
        @(negedge clk);
        check("d3_req", 64'(imem_req_o), 64'd0);
        check("d3_valid", 64'(instr_valid_o), 64'd0);
        next_cycle(); @(negedge clk);
        check("d4_req", 64'(imem_req_o), 64'd1);
        check("d4_addr", 64'(imem_addr_o), 64'h100);
        next_cycle(); @(negedge clk);
        check("d5_addr", 64'(imem_addr_o), 64'h104);
        next_cycle();
        next_cycle(); @(negedge clk);
        check("d7_valid", 64'(instr_valid_o), 64'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        next_cycle(); @(negedge clk);
        check_head("d8");
        next_cycle(); @(negedge clk);
        check_head("d9");

        // 3-cycle memory, in-order delivery with tags
        do_reset(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        @(negedge clk);
        next_cycle(); @(negedge clk);
        next_cycle(); @(negedge clk);
        check("e2_req", 64'(imem_req_o), 64'd0);
        next_cycle(); @(negedge clk);
        check("e3_valid", 64'(instr_valid_o), 64'd0);
        next_cycle(); @(negedge clk);
        check_head("e4");
        next_cycle(); @(negedge clk);
        check_head("e5");
        next_cycle(); @(negedge clk);
        check("e6_valid", 64'(instr_valid_o), 64'd0);
        next_cycle();
        next_cycle(); @(negedge clk);
        check_head("e8");
        check("e_sb_drained", 64'(exp_q.size()), 64'd0);

        // PC wrap near the top of the address space, then reset mid-burst
        do_reset(1);
        branch = 1'b1;
        target = 32'hFFFF_FFF8;
        @(negedge clk);
        check("f0_req", 64'(imem_req_o), 64'd0);
        next_cycle();
        branch = 1'b0;
        @(negedge clk);
        check("f1_addr", 64'(imem_addr_o), 64'hFFFF_FFF8);
        next_cycle(); @(negedge clk);
        check("f2_addr", 64'(imem_addr_o), 64'hFFFF_FFFC);
        next_cycle(); @(negedge clk);
        check("f3_instr", 64'(instr_o), 64'hFFFF_FFF8);
        check("f3_req", 64'(imem_req_o), 64'd1);
        check("f3_addr_wrap", 64'(imem_addr_o), 64'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("f4_pc", 64'(instr_pc_o), 64'hFFFF_FFFC);
        check("f4_req_in_rst", 64'(imem_req_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("f5_valid", 64'(instr_valid_o), 64'd0);
        check("f5_instr", 64'(instr_o), 64'h0);
        check("f5_req", 64'(imem_req_o), 64'd1);
        check("f5_addr", 64'(imem_addr_o), 64'h0);
        next_cycle(); @(negedge clk);
        check("f6_addr", 64'(imem_addr_o), 64'h4);

        check("max_outstanding_ok", 64'(max_out <= DEPTH), 64'd1);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
